// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   pll_state_t : sequencer state encoding
//   DEF_*       : default cycle counts for a 50 MHz board clock
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_t;

  // 16 cycles = 320 ns of PLL reset at 50 MHz.
  localparam int DEF_PLL_RST_CYCLES      = 16;
  // ~20 us of uninterrupted lock before the system domains come out of reset.
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  // ~1.3 ms from PLL reset release until we give up on this attempt.
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_RETRY_W             = 4;

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// bit_sync: two-flop synchronizer for a single level signal.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both flops to 0
//   d   - asynchronous input level
//   q   - synchronized level, two destination cycles of latency
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds the PLL in reset, waits for a stable lock, then
// releases the system reset for the PLL-derived clock domains. Lock loss or a
// lock timeout restarts the sequence.
// Ports:
//   clk_in     - 50 MHz board clock, the only clock
//   areset     - asynchronous active-high reset
//   pll_locked - PLL lock flag, asynchronous to clk_in
//   pll_areset - reset to the PLL, active-high
//   sys_reset  - system reset, active-high, released synchronously
//   ready      - high only while running
//   retries    - restarted attempts since areset, saturating
//   fail       - sticky failure flag
// Build option: define PLL_SEQ_FAIL_EN to enter a sticky FAIL state on a
// timeout once MAX_RETRIES attempts have already failed. Without it the
// sequencer retries forever and fail is tied low.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
`ifdef PLL_SEQ_FAIL_EN
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
`endif
  parameter int RETRY_W             = DEF_RETRY_W
) (
  input  logic               clk_in,
  input  logic               areset,
  input  logic               pll_locked,
  output logic               pll_areset,
  output logic               sys_reset,
  output logic               ready,
  output logic [RETRY_W-1:0] retries,
  output logic               fail
);

  localparam int CNT_W  = $clog2(PLL_RST_CYCLES + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  logic lock_s;

  bit_sync u_lock_sync (
    .clk (clk_in),
    .rst (areset),
    .d   (pll_locked),
    .q   (lock_s)
  );

  pll_state_t         state_reg,      state_next;
  logic [CNT_W-1:0]   cnt_reg,        cnt_next;
  logic [TMO_W-1:0]   tmo_reg,        tmo_next;
  logic [STAB_W-1:0]  stab_reg,       stab_next;
  logic [RETRY_W-1:0] retries_reg,    retries_next;
  logic               pll_areset_reg, pll_areset_next;
  logic               sys_reset_reg,  sys_reset_next;
  logic               ready_reg,      ready_next;

  logic [TMO_W-1:0]   tmo_inc;
  logic [STAB_W-1:0]  stab_cand;
  logic [RETRY_W-1:0] retries_inc;
  logic               timeout;

`ifdef PLL_SEQ_FAIL_EN
  logic fail_reg, fail_next;
`endif

  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      state_reg      <= RESET_PLL;
      cnt_reg        <= '0;
      tmo_reg        <= '0;
      stab_reg       <= '0;
      retries_reg    <= '0;
      pll_areset_reg <= 1'b1;
      sys_reset_reg  <= 1'b1;
      ready_reg      <= 1'b0;
`ifdef PLL_SEQ_FAIL_EN
      fail_reg       <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      tmo_reg        <= tmo_next;
      stab_reg       <= stab_next;
      retries_reg    <= retries_next;
      pll_areset_reg <= pll_areset_next;
      sys_reset_reg  <= sys_reset_next;
      ready_reg      <= ready_next;
`ifdef PLL_SEQ_FAIL_EN
      fail_reg       <= fail_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    tmo_next        = tmo_reg;
    stab_next       = stab_reg;
    retries_next    = retries_reg;
    pll_areset_next = pll_areset_reg;
    sys_reset_next  = sys_reset_reg;
    ready_next      = ready_reg;
`ifdef PLL_SEQ_FAIL_EN
    fail_next       = fail_reg;
`endif

    // tmo counts cycles since PLL reset release; reaching the limit on this
    // edge is the timeout, so the PLL reset reasserts exactly
    // LOCK_TIMEOUT_CYCLES cycles after it was released.
    tmo_inc     = tmo_reg + TMO_W'(1);
    timeout     = (tmo_inc == TMO_W'(LOCK_TIMEOUT_CYCLES));
    retries_inc = (&retries_reg) ? retries_reg : retries_reg + RETRY_W'(1);
    // stab counts lock cycles seen so far including the current one; the
    // first lock cycle is the one that moves WAIT_LOCK into STABLE.
    stab_cand   = (state_reg == WAIT_LOCK) ? STAB_W'(1) : stab_reg + STAB_W'(1);

    case (state_reg)
      RESET_PLL: begin
        if (cnt_reg == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_next      = WAIT_LOCK;
          pll_areset_next = 1'b0;
          tmo_next        = '0;
          stab_next       = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      WAIT_LOCK, STABLE: begin
        tmo_next = tmo_inc;
        if (timeout) begin
`ifdef PLL_SEQ_FAIL_EN
          if (retries_reg == RETRY_W'(MAX_RETRIES)) begin
            state_next      = FAIL;
            pll_areset_next = 1'b1;
            sys_reset_next  = 1'b1;
            ready_next      = 1'b0;
            fail_next       = 1'b1;
          end else begin
            state_next      = RESET_PLL;
            cnt_next        = '0;
            pll_areset_next = 1'b1;
            retries_next    = retries_inc;
          end
`else
          state_next      = RESET_PLL;
          cnt_next        = '0;
          pll_areset_next = 1'b1;
          retries_next    = retries_inc;
`endif
        end else if (lock_s) begin
          if (stab_cand == STAB_W'(LOCK_STABLE_CYCLES)) begin
            state_next     = RUN;
            sys_reset_next = 1'b0;
            ready_next     = 1'b1;
          end else begin
            state_next = STABLE;
            stab_next  = stab_cand;
          end
        end else begin
          // A dropout restarts the stability window but not the timeout.
          state_next = WAIT_LOCK;
          stab_next  = '0;
        end
      end

      RUN: begin
        if (!lock_s) begin
          state_next      = RESET_PLL;
          cnt_next        = '0;
          pll_areset_next = 1'b1;
          sys_reset_next  = 1'b1;
          ready_next      = 1'b0;
          retries_next    = retries_inc;
        end
      end

`ifdef PLL_SEQ_FAIL_EN
      FAIL: begin
        // Sticky until areset.
        state_next = FAIL;
      end
`endif

      default: begin
        state_next      = RESET_PLL;
        cnt_next        = '0;
        pll_areset_next = 1'b1;
        sys_reset_next  = 1'b1;
        ready_next      = 1'b0;
      end
    endcase
  end

  assign pll_areset = pll_areset_reg;
  assign sys_reset  = sys_reset_reg;
  assign ready      = ready_reg;
  assign retries    = retries_reg;
`ifdef PLL_SEQ_FAIL_EN
  assign fail       = fail_reg;
`else
  assign fail       = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8,
// LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2). Define PLL_SEQ_FAIL_EN to build the
// FAIL-state variant. Expected output changes are queued with the cycle they
// must appear on; a monitor pops and compares on every output change.
module tb_pll_reset_sequencer;

  localparam int RETRY_W = 4;
  localparam int RST_VALS = 8'hC0; // pll_areset=1 sys_reset=1 ready=0 fail=0 retries=0

  logic               clk_in;
  logic               areset;
  logic               pll_locked;
  logic               pll_areset;
  logic               sys_reset;
  logic               ready;
  logic [RETRY_W-1:0] retries;
  logic               fail;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
`ifdef PLL_SEQ_FAIL_EN
    .MAX_RETRIES         (2),
`endif
    .RETRY_W             (RETRY_W)
  ) dut (
    .clk_in     (clk_in),
    .areset     (areset),
    .pll_locked (pll_locked),
    .pll_areset (pll_areset),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .retries    (retries),
    .fail       (fail)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int         cyc;
    logic [7:0] vals;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   base  = 0;
  logic mon_en = 1'b0;
  logic [7:0] prev = 8'h00;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] pack_out();
    return {pll_areset, sys_reset, ready, fail, retries};
  endfunction

  task automatic push(input int c, input bit pa, input bit sr, input bit rd,
                      input bit fl, input int rt);
    exp_t x;
    x.cyc  = c;
    x.vals = {pa, sr, rd, fl, 4'(rt)};
    exp_q.push_back(x);
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // Output-change monitor: each change is one transaction.
  always @(negedge clk_in) begin
    if (mon_en && pack_out() !== prev) begin
      $display("cycle %0d: pll_areset=%0b sys_reset=%0b ready=%0b fail=%0b retries=%0d",
               cyc - base, pll_areset, sys_reset, ready, fail, retries);
      if (exp_q.size() == 0) begin
        check("unexpected_change", int'(pack_out()), int'(prev));
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc - base, e.cyc);
        check("event_outputs", int'(pack_out()), int'(e.vals));
      end
    end
    prev <= pack_out();
  end

  task automatic wait_cyc(input int n);
    while (cyc - base < n) @(negedge clk_in);
  endtask

  task automatic do_reset();
    mon_en     = 1'b0;
    pll_locked = 1'b0;
    areset     = 1'b1;
    #1;
    check("reset_outputs", int'(pack_out()), RST_VALS);
    @(negedge clk_in);
    @(negedge clk_in);
    areset = 1'b0;
    base   = cyc;
    mon_en = 1'b1;
  endtask

  initial begin
    areset     = 1'b1;
    pll_locked = 1'b0;

    // Nominal bring-up.
    do_reset();
    push(4, 0, 1, 0, 0, 0);
    wait_cyc(6);
    pll_locked = 1'b1;
    push(16, 0, 0, 1, 0, 0);
    wait_cyc(20);
    check("nominal_ready", ready, 1);
    check("nominal_retries", retries, 0);

    // Lock loss while running, then recovery.
    pll_locked = 1'b0;
    push(23, 1, 1, 0, 0, 1);
    push(27, 0, 1, 0, 0, 1);
    wait_cyc(24);
    pll_locked = 1'b1;
    push(35, 0, 0, 1, 0, 1);
    wait_cyc(40);
    check("lockloss_pending", exp_q.size(), 0);

    // One-cycle lock glitch at stab=5 restarts the stability window.
    do_reset();
    push(4, 0, 1, 0, 0, 0);
    wait_cyc(6);
    pll_locked = 1'b1;
    wait_cyc(12);
    pll_locked = 1'b0;
    wait_cyc(13);
    pll_locked = 1'b1;
    push(23, 0, 0, 1, 0, 0);
    wait_cyc(28);
    check("glitch_pending", exp_q.size(), 0);
    check("glitch_retries", retries, 0);

    // Late glitch: stability would complete on the timeout edge; the timeout
    // (not restarted by the glitch) must win. Then areset while in STABLE.
    do_reset();
    push(4, 0, 1, 0, 0, 0);
    wait_cyc(20);
    pll_locked = 1'b1;
    wait_cyc(25);
    pll_locked = 1'b0;
    wait_cyc(26);
    pll_locked = 1'b1;
    push(36, 1, 1, 0, 0, 1);
    push(40, 0, 1, 0, 0, 1);
    wait_cyc(44);
    check("tmo_priority_pending", exp_q.size(), 0);
    #2;
    mon_en = 1'b0;
    areset = 1'b1;
    #1;
    check("areset_in_stable", int'(pack_out()), RST_VALS);

    // Lock never arrives.
    do_reset();
    push(4, 0, 1, 0, 0, 0);
`ifdef PLL_SEQ_FAIL_EN
    push(36, 1, 1, 0, 0, 1);
    push(40, 0, 1, 0, 0, 1);
    push(72, 1, 1, 0, 0, 2);
    push(76, 0, 1, 0, 0, 2);
    push(108, 1, 1, 0, 1, 2);
    wait_cyc(150);
    check("fail_pending", exp_q.size(), 0);
    check("fail_sticky", fail, 1);
    check("fail_pll_areset", pll_areset, 1);
    check("fail_sys_reset", sys_reset, 1);
    do_reset();
`else
    for (int k = 1; k <= 16; k++) begin
      push(36 * k,     1, 1, 0, 0, (k > 15) ? 15 : k);
      push(36 * k + 4, 0, 1, 0, 0, (k > 15) ? 15 : k);
    end
    wait_cyc(16 * 36 + 8);
    check("timeout_pending", exp_q.size(), 0);
    check("retries_saturated", retries, 15);
    check("fail_tied_low", fail, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
